relu_maxpool_2x2: RTL and testbench

- Downstream stage of the 2D convolution engine. Consumes its serial stream of signed 22-bit results: 30x30 valid outputs per frame for a 32x32 image with a 3x3 kernel, raster order.
- Applies ReLU and requantizes each result to unsigned 8 bits (right shift plus saturation).
- Performs 2x2 stride-2 max pooling and emits a 15x15 raster stream to the next layer.
- Uses a single half-row line buffer; no frame storage.

---
 rtl/relu_maxpool_2x2.sv | 115 +++++++++++
 tb/tb_relu_maxpool_2x2.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool_2x2.sv
// ReLU + requantize + 2x2 stride-2 max pooling on the serial convolution stream.
// One half-row line buffer carries the horizontal maxima of each even row.
//
// state | meaning
// IDLE  | waiting for start_signal, conv inputs ignored
// RUN   | consuming samples, pooling windows as they complete
// DONE  | one-cycle end-of-frame pulse (normal or aborted)
module relu_maxpool_2x2 #(
    parameter int IN_WIDTH  = 22,
    parameter int FMAP_SIZE = 30,
    parameter int SHIFT     = 4,
    parameter int OUT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_signal,
    input  logic signed [IN_WIDTH-1:0] conv_in,
    input  logic                       conv_valid,
    input  logic                       conv_done,
    output logic [OUT_WIDTH-1:0]       pool_out,
    output logic                       pool_valid,
    output logic                       done_signal,
    output logic                       frame_err
);

    localparam int CW   = $clog2(FMAP_SIZE);
    localparam int HALF = FMAP_SIZE / 2;
    localparam logic [CW-1:0]        LAST_IDX = CW'(FMAP_SIZE - 1);
    localparam logic [OUT_WIDTH-1:0] Q_MAX    = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]        col, row;
    logic [OUT_WIDTH-1:0] hmax;
    logic [OUT_WIDTH-1:0] linebuf [HALF];

    logic signed [IN_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0]       q, h_q, lb_rd, win_max;
    logic                       accept, last_acc, abort;

    assign shifted = conv_in >>> SHIFT;

    always_comb begin
        q = shifted[OUT_WIDTH-1:0];
        if (conv_in[IN_WIDTH-1])
            q = '0;
        else if ($unsigned(shifted) > IN_WIDTH'(Q_MAX))
            q = Q_MAX;
    end

    assign accept   = (state == RUN) && conv_valid;
    assign last_acc = accept && (row == LAST_IDX) && (col == LAST_IDX);
    // A conv_done arriving together with the final sample is a normal end.
    assign abort    = (state == RUN) && conv_done && !last_acc;

    assign h_q     = (q > hmax) ? q : hmax;
    assign lb_rd   = linebuf[col[CW-1:1]];
    assign win_max = (lb_rd > h_q) ? lb_rd : h_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_signal) state_nxt = RUN;
            RUN:     if (last_acc || abort) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    assign done_signal = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            hmax       <= '0;
            pool_out   <= '0;
            pool_valid <= 1'b0;
            frame_err  <= 1'b0;
            for (int i = 0; i < HALF; i++) linebuf[i] <= '0;
        end else begin
            pool_valid <= 1'b0;
            if ((state == IDLE) && start_signal) begin
                col       <= '0;
                row       <= '0;
                frame_err <= 1'b0;
            end
            if (abort) frame_err <= 1'b1;
            if (accept) begin
                if (col == LAST_IDX) begin
                    col <= '0;
                    row <= row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (!col[0]) begin
                    hmax <= q;
                end else if (!row[0]) begin
                    linebuf[col[CW-1:1]] <= h_q;
                end else begin
                    pool_out   <= win_max;
                    pool_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Directed bench for relu_maxpool_2x2: ramp, negative, saturation, gaps, abort and reset cases.
module tb_relu_maxpool_2x2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start_signal = 1'b0;
    logic signed [21:0] conv_in = '0;
    logic               conv_valid = 1'b0;
    logic               conv_done = 1'b0;
    logic [7:0]         pool_out;
    logic               pool_valid;
    logic               done_signal;
    logic               frame_err;

    relu_maxpool_2x2 dut (
        .clk          (clk),
        .rst          (rst),
        .start_signal (start_signal),
        .conv_in      (conv_in),
        .conv_valid   (conv_valid),
        .conv_done    (conv_done),
        .pool_out     (pool_out),
        .pool_valid   (pool_valid),
        .done_signal  (done_signal),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int got_val[$];
    int got_cyc[$];
    int exp_cyc[$];
    int done_cnt = 0;
    int done_pv  = 0;

    always @(negedge clk) begin
        if (pool_valid) begin
            got_val.push_back(int'(pool_out));
            got_cyc.push_back(cyc);
        end
        if (done_signal) begin
            done_cnt++;
            done_pv = int'(pool_valid);
        end
    end

    function automatic int ramp_q(input int r, input int c);
        int v;
        v = ((2 * r + 1) * 30 + 2 * c + 1) >> 4;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int sample(input int mode, input int k);
        if (mode == 0) return k;
        if (mode == 1) return -300;
        case (k)
            0:       return 5000;
            1:       return 1000;
            30:      return -7;
            31:      return 16;
            default: return 0;
        endcase
    endfunction

    task automatic clear_mon();
        got_val.delete();
        got_cyc.delete();
        exp_cyc.delete();
        done_cnt = 0;
        done_pv  = 0;
    endtask

    task automatic start_frame();
        @(negedge clk) start_signal = 1'b1;
        @(negedge clk) start_signal = 1'b0;
    endtask

    // done_mode: 0 none, 1 conv_done with the last sample, 2 conv_done the cycle after
    task automatic feed(input int mode, input int n, input bit gaps, input int done_mode,
                        input bit poke_start);
        bit poked;
        int r, c;
        poked = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                @(negedge clk);
                conv_valid = 1'b0;
                if (poke_start && k >= 500 && !poked) begin
                    start_signal = 1'b1;
                    poked = 1'b1;
                end
            end
            @(negedge clk);
            start_signal = 1'b0;
            conv_valid   = 1'b1;
            conv_in      = 22'(sample(mode, k));
            conv_done    = (done_mode == 1) && (k == n - 1);
            r = k / 30;
            c = k % 30;
            if ((r % 2 == 1) && (c % 2 == 1)) exp_cyc.push_back(cyc + 1);
        end
        @(negedge clk);
        conv_valid = 1'b0;
        conv_in    = '0;
        conv_done  = (done_mode == 2);
        @(negedge clk) conv_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (pool_out !== 8'd0 || pool_valid !== 1'b0 || done_signal !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%0d v=%0b d=%0b e=%0b expected all 0",
                     pool_out, pool_valid, done_signal, frame_err);
        end
        @(negedge clk) rst = 1'b1;
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            conv_valid = 1'b1;
            conv_in    = 22'(1000 + i);
            conv_done  = (i == 3);
        end
        @(negedge clk);
        conv_valid = 1'b0;
        conv_done  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (got_val.size() !== 0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL idle_ignores_inputs: got %0d pulses %0d done, expected 0 and 0",
                     got_val.size(), done_cnt);
        end
    endtask

    task automatic test_ramp();
        clear_mon();
        start_frame();
        feed(0, 900, 1'b0, 1, 1'b0);
        checks++;
        if (got_val.size() !== 225) begin
            errors++;
            $display("FAIL ramp_count: got %0d expected 225", got_val.size());
        end
        for (int i = 0; i < got_val.size() && i < 225; i++) begin
            checks++;
            if (got_val[i] !== ramp_q(i / 15, i % 15)) begin
                errors++;
                $display("FAIL ramp_value[%0d]: got %0d expected %0d", i, got_val[i], ramp_q(i / 15, i % 15));
            end
            checks++;
            if (got_cyc[i] !== exp_cyc[i]) begin
                errors++;
                $display("FAIL ramp_latency[%0d]: got cycle %0d expected %0d", i, got_cyc[i], exp_cyc[i]);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_pv !== 1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL ramp_done: got done=%0d with_valid=%0d err=%0b expected 1 1 0",
                     done_cnt, done_pv, frame_err);
        end
    endtask

    task automatic test_saturation();
        clear_mon();
        start_frame();
        feed(2, 32, 1'b0, 2, 1'b0);
        checks++;
        if (got_val.size() !== 1) begin
            errors++;
            $display("FAIL sat_count: got %0d expected 1", got_val.size());
        end else begin
            checks++;
            if (got_val[0] !== 255) begin
                errors++;
                $display("FAIL sat_value: got %0d expected 255", got_val[0]);
            end
        end
        checks++;
        if (done_cnt !== 1 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL sat_abort: got done=%0d err=%0b expected 1 1", done_cnt, frame_err);
        end
    endtask

    // Leaves the block armed for the next frame.
    task automatic test_abort();
        int e;
        clear_mon();
        start_frame();
        feed(0, 100, 1'b0, 2, 1'b0);
        checks++;
        if (got_val.size() !== 20) begin
            errors++;
            $display("FAIL abort_count: got %0d expected 20", got_val.size());
        end
        for (int i = 0; i < got_val.size() && i < 20; i++) begin
            e = (i < 15) ? ramp_q(0, i) : ramp_q(1, i - 15);
            checks++;
            if (got_val[i] !== e) begin
                errors++;
                $display("FAIL abort_value[%0d]: got %0d expected %0d", i, got_val[i], e);
            end
        end
        checks++;
        if (done_cnt !== 1 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL abort_flags: got done=%0d err=%0b expected 1 1", done_cnt, frame_err);
        end
        clear_mon();
        @(negedge clk) conv_done = 1'b1;
        @(negedge clk) conv_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt !== 0 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle_done: got done=%0d err=%0b expected 0 1", done_cnt, frame_err);
        end
        start_frame();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_err_clear: got %0b expected 0", frame_err);
        end
    endtask

    task automatic test_negative();
        int nz;
        clear_mon();
        feed(1, 900, 1'b0, 0, 1'b0);
        nz = 0;
        foreach (got_val[i]) if (got_val[i] != 0) nz++;
        checks++;
        if (got_val.size() !== 225 || nz !== 0) begin
            errors++;
            $display("FAIL neg_outputs: got %0d pulses %0d nonzero expected 225 0", got_val.size(), nz);
        end
        checks++;
        if (done_cnt !== 1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL neg_flags: got done=%0d err=%0b expected 1 0", done_cnt, frame_err);
        end
    endtask

    task automatic test_back_to_back_gaps();
        clear_mon();
        start_frame();
        feed(0, 900, 1'b1, 0, 1'b1);
        checks++;
        if (got_val.size() !== 225) begin
            errors++;
            $display("FAIL gaps_count: got %0d expected 225", got_val.size());
        end
        for (int i = 0; i < got_val.size() && i < 225; i++) begin
            checks++;
            if (got_val[i] !== ramp_q(i / 15, i % 15)) begin
                errors++;
                $display("FAIL gaps_value[%0d]: got %0d expected %0d", i, got_val[i], ramp_q(i / 15, i % 15));
            end
            checks++;
            if (got_cyc[i] !== exp_cyc[i]) begin
                errors++;
                $display("FAIL gaps_latency[%0d]: got cycle %0d expected %0d", i, got_cyc[i], exp_cyc[i]);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_pv !== 1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL gaps_done: got done=%0d with_valid=%0d err=%0b expected 1 1 0",
                     done_cnt, done_pv, frame_err);
        end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        start_frame();
        feed(0, 400, 1'b0, 0, 1'b0);
        checks++;
        if (got_val.size() !== 95 || pool_out !== 8'(ramp_q(6, 4))) begin
            errors++;
            $display("FAIL mid_before_reset: got %0d pulses out=%0d expected 95 %0d",
                     got_val.size(), pool_out, ramp_q(6, 4));
        end
        @(negedge clk) rst = 1'b0;
        #1;
        checks++;
        if (pool_out !== 8'd0 || pool_valid !== 1'b0 || done_signal !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got out=%0d v=%0b d=%0b expected 0 0 0",
                     pool_out, pool_valid, done_signal);
        end
        clear_mon();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (got_val.size() !== 0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL mid_no_pulses: got %0d pulses %0d done expected 0 0", got_val.size(), done_cnt);
        end
        clear_mon();
        start_frame();
        feed(0, 900, 1'b0, 0, 1'b0);
        checks++;
        if (got_val.size() !== 225) begin
            errors++;
            $display("FAIL mid_refill_count: got %0d expected 225", got_val.size());
        end
        for (int i = 0; i < got_val.size() && i < 225; i++) begin
            checks++;
            if (got_val[i] !== ramp_q(i / 15, i % 15)) begin
                errors++;
                $display("FAIL mid_refill_value[%0d]: got %0d expected %0d", i, got_val[i], ramp_q(i / 15, i % 15));
            end
        end
        checks++;
        if (done_cnt !== 1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_refill_done: got done=%0d err=%0b expected 1 0", done_cnt, frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_saturation();
        test_abort();
        test_negative();
        test_back_to_back_gaps();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
